// File: rtl/regfile_wb_port_pkg.sv
// Shared widths, index/data types and the scoreboard counter operation
// for the register-file writeback port.
package regfile_wb_port_pkg;

  localparam int DATA_W       = 8;
  localparam int NREGS        = 4;
  localparam int AW           = $clog2(NREGS);
  localparam int MAX_INFLIGHT = 3;
  localparam int CW           = $clog2(MAX_INFLIGHT + 1);

  typedef logic [AW-1:0]     reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CW-1:0]     cnt_t;

  typedef enum logic [1:0] {
    SB_HOLD,
    SB_INC,
    SB_DEC,
    SB_CLR
  } sb_op_e;

  // Clear beats everything; a matched issue and writeback cancel out.
  function automatic sb_op_e sb_op(input logic inc, input logic dec, input logic clr);
    if (clr)
      return SB_CLR;
    else if (inc && !dec)
      return SB_INC;
    else if (dec && !inc)
      return SB_DEC;
    else
      return SB_HOLD;
  endfunction

endpackage

// File: rtl/regfile_wb_port_if.sv
// Writeback, issue and operand-read signals between the pipeline and
// the register file.
interface regfile_wb_port_if;
  import regfile_wb_port_pkg::*;

  logic     wb_we;
  reg_idx_t wb_rd;
  data_t    wb_data;
  logic     iss_valid;
  reg_idx_t iss_rd;
  logic     flush;
  reg_idx_t rs_addr;
  reg_idx_t rt_addr;
  data_t    rs_data;
  data_t    rt_data;
  logic     stall;
  logic     sb_overflow;

  modport master (
    output wb_we, wb_rd, wb_data, iss_valid, iss_rd, flush, rs_addr, rt_addr,
    input  rs_data, rt_data, stall, sb_overflow
  );

  modport slave (
    input  wb_we, wb_rd, wb_data, iss_valid, iss_rd, flush, rs_addr, rt_addr,
    output rs_data, rt_data, stall, sb_overflow
  );

endinterface

// File: rtl/regfile_wb_port_sb_counter.sv
// Per-register in-flight write counter: saturating up/down with a
// synchronous clear.
module sb_counter
  import regfile_wb_port_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_dec,
  input  logic i_clr,
  output cnt_t o_count,
  output logic o_at_max
);

  cnt_t   r_count;
  cnt_t   w_next;
  sb_op_e w_op;

  always_comb begin
    w_op   = sb_op(i_inc, i_dec, i_clr);
    w_next = r_count;
    unique case (w_op)
      SB_CLR:  w_next = '0;
      SB_INC:  if (r_count != cnt_t'(MAX_INFLIGHT)) w_next = r_count + cnt_t'(1);
      SB_DEC:  if (r_count != '0) w_next = r_count - cnt_t'(1);
      SB_HOLD: w_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_count <= '0;
    else
      r_count <= w_next;
  end

  assign o_count  = r_count;
  assign o_at_max = (r_count == cnt_t'(MAX_INFLIGHT));

endmodule

// File: rtl/regfile_wb_port.sv
// Architectural register file with write-through bypass reads and a
// per-register in-flight scoreboard that stalls decode on pending operands.
module regfile_wb_port
  import regfile_wb_port_pkg::*;
(
  input  logic clk,
  input  logic rst,
  regfile_wb_port_if.slave io_bus
);

  data_t            r_regs [NREGS];
  logic             r_overflow;
  logic [NREGS-1:0] w_inc;
  logic [NREGS-1:0] w_dec;
  logic [NREGS-1:0] w_at_max;
  cnt_t             w_count    [NREGS];
  cnt_t             w_pend_eff [NREGS];
  logic             w_stall;
  logic             w_ovf_hit;

  // A writeback landing this cycle already retires its count for stall purposes.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      w_dec[r]      = io_bus.wb_we && (io_bus.wb_rd == reg_idx_t'(r)) && (w_count[r] != '0);
      w_pend_eff[r] = w_count[r] - cnt_t'(w_dec[r]);
    end
  end

  assign w_stall = !rst && ((w_pend_eff[io_bus.rs_addr] != '0) ||
                            (w_pend_eff[io_bus.rt_addr] != '0));

  always_comb begin
    for (int r = 0; r < NREGS; r++)
      w_inc[r] = io_bus.iss_valid && (io_bus.iss_rd == reg_idx_t'(r)) && !w_stall;
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_sb
    sb_counter u_cnt (
      .clk      (clk),
      .rst      (rst),
      .i_inc    (w_inc[g]),
      .i_dec    (w_dec[g]),
      .i_clr    (io_bus.flush),
      .o_count  (w_count[g]),
      .o_at_max (w_at_max[g])
    );
  end

  assign w_ovf_hit = (|(w_inc & ~w_dec & w_at_max)) && !io_bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++)
        r_regs[r] <= '0;
    end else if (io_bus.wb_we) begin
      r_regs[io_bus.wb_rd] <= io_bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_overflow <= 1'b0;
    else if (w_ovf_hit)
      r_overflow <= 1'b1;
  end

  assign io_bus.rs_data = (io_bus.wb_we && (io_bus.wb_rd == io_bus.rs_addr)) ?
                          io_bus.wb_data : r_regs[io_bus.rs_addr];
  assign io_bus.rt_data = (io_bus.wb_we && (io_bus.wb_rd == io_bus.rt_addr)) ?
                          io_bus.wb_data : r_regs[io_bus.rt_addr];
  assign io_bus.stall       = w_stall;
  assign io_bus.sb_overflow = r_overflow;

endmodule

// File: tb/tb_regfile_wb_port.sv
// Directed self-checking bench for regfile_wb_port: inputs change on the
// falling edge, outputs are checked 1 ns later, state updates on the rising edge.
module tb_regfile_wb_port;
  import regfile_wb_port_pkg::*;

  logic clk;
  logic rst;
  int   testCount;
  int   failCount;

  regfile_wb_port_if bus ();

  regfile_wb_port dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input reg_idx_t rd, input data_t data,
                               input logic iv, input reg_idx_t ird, input logic fl,
                               input reg_idx_t rs, input reg_idx_t rt);
    @(negedge clk);
    bus.wb_we     = we;
    bus.wb_rd     = rd;
    bus.wb_data   = data;
    bus.iss_valid = iv;
    bus.iss_rd    = ird;
    bus.flush     = fl;
    bus.rs_addr   = rs;
    bus.rt_addr   = rt;
    #1;
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0);
    rst = 1'b0;

    // Reset state
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd2, 2'd3);
    checkOutput("reset_rs", 32'(bus.rs_data), 32'h00);
    checkOutput("reset_rt", 32'(bus.rt_data), 32'h00);
    checkOutput("reset_stall", 32'(bus.stall), 32'h0);
    checkOutput("reset_ovf", 32'(bus.sb_overflow), 32'h0);

    // Write with bypass, then stored read, then both ports on one index
    applyStimulus(1'b1, 2'd1, 8'hA5, 1'b0, 2'd0, 1'b0, 2'd1, 2'd0);
    checkOutput("bypass_rs", 32'(bus.rs_data), 32'hA5);
    checkOutput("bypass_rt_other", 32'(bus.rt_data), 32'h00);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd1, 2'd1);
    checkOutput("stored_rs", 32'(bus.rs_data), 32'hA5);
    checkOutput("same_idx_rt", 32'(bus.rt_data), 32'hA5);
    checkOutput("wb_no_pend_stall", 32'(bus.stall), 32'h0);

    // Hazard on r2; an issue to r1 while stalled must be dropped
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b0, 2'd0, 2'd0);
    checkOutput("issue_no_stall", 32'(bus.stall), 32'h0);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd2, 2'd0);
    checkOutput("hazard_stall1", 32'(bus.stall), 32'h1);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b0, 2'd2, 2'd0);
    checkOutput("hazard_stall2", 32'(bus.stall), 32'h1);
    applyStimulus(1'b1, 2'd2, 8'h3C, 1'b0, 2'd0, 1'b0, 2'd2, 2'd0);
    checkOutput("hazard_release", 32'(bus.stall), 32'h0);
    checkOutput("hazard_bypass", 32'(bus.rs_data), 32'h3C);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd2, 2'd1);
    checkOutput("hazard_cleared", 32'(bus.stall), 32'h0);
    checkOutput("hazard_stored", 32'(bus.rs_data), 32'h3C);

    // Simultaneous issue and writeback on r0 keep pend[0] at 1
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b0, 2'd3, 2'd3);
    applyStimulus(1'b1, 2'd0, 8'h11, 1'b1, 2'd0, 1'b0, 2'd3, 2'd3);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 2'd3);
    checkOutput("incdec_stall", 32'(bus.stall), 32'h1);
    checkOutput("incdec_data", 32'(bus.rs_data), 32'h11);
    applyStimulus(1'b1, 2'd0, 8'h22, 1'b0, 2'd0, 1'b0, 2'd3, 2'd0);
    checkOutput("incdec_release", 32'(bus.stall), 32'h0);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0);
    checkOutput("incdec_cleared", 32'(bus.stall), 32'h0);
    checkOutput("incdec_stored", 32'(bus.rs_data), 32'h22);

    // Saturation on r3 and sticky overflow
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b0, 2'd0, 2'd0);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd3, 2'd0);
    checkOutput("sat_stall", 32'(bus.stall), 32'h1);
    checkOutput("sat_no_ovf_yet", 32'(bus.sb_overflow), 32'h0);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b0, 2'd0, 2'd0);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0);
    checkOutput("sat_ovf_set", 32'(bus.sb_overflow), 32'h1);
    applyStimulus(1'b1, 2'd3, 8'h01, 1'b0, 2'd0, 1'b0, 2'd3, 2'd3);
    checkOutput("sat_drain3", 32'(bus.stall), 32'h1);
    applyStimulus(1'b1, 2'd3, 8'h02, 1'b0, 2'd0, 1'b0, 2'd3, 2'd3);
    checkOutput("sat_drain2", 32'(bus.stall), 32'h1);
    applyStimulus(1'b1, 2'd3, 8'h03, 1'b0, 2'd0, 1'b0, 2'd3, 2'd3);
    checkOutput("sat_drain1", 32'(bus.stall), 32'h0);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd3, 2'd3);
    checkOutput("sat_empty", 32'(bus.stall), 32'h0);
    checkOutput("sat_data", 32'(bus.rs_data), 32'h03);
    checkOutput("sat_ovf_sticky", 32'(bus.sb_overflow), 32'h1);

    // Flush with pend[1]=2, pend[2]=1, same-cycle writeback and ignored issue
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b0, 2'd0, 2'd0);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b0, 2'd0, 2'd0);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b0, 2'd0, 2'd0);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd1, 2'd0);
    checkOutput("pre_flush_stall", 32'(bus.stall), 32'h1);
    applyStimulus(1'b1, 2'd1, 8'h77, 1'b1, 2'd2, 1'b1, 2'd0, 2'd0);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd1, 2'd2);
    checkOutput("flush_stall", 32'(bus.stall), 32'h0);
    checkOutput("flush_wb_data", 32'(bus.rs_data), 32'h77);
    checkOutput("flush_keeps_ovf", 32'(bus.sb_overflow), 32'h1);

    // Reset mid-operation: stall forced low, reset beats writeback
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b0, 2'd0, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.wb_we     = 1'b1;
    bus.wb_rd     = 2'd1;
    bus.wb_data   = 8'hEE;
    bus.iss_valid = 1'b0;
    bus.rs_addr   = 2'd0;
    bus.rt_addr   = 2'd0;
    #1;
    checkOutput("rst_stall_pre", 32'(bus.stall), 32'h0);
    bus.rs_addr   = 2'd2;
    bus.rt_addr   = 2'd3;
    bus.wb_rd     = 2'd2;
    bus.wb_data   = 8'hEE;
    #1;
    checkOutput("rst_stall_low", 32'(bus.stall), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.wb_we = 1'b0;
    bus.rs_addr = 2'd1;
    bus.rt_addr = 2'd2;
    #1;
    checkOutput("rst_wins_r1", 32'(bus.rs_data), 32'h00);
    checkOutput("rst_wins_r2", 32'(bus.rt_data), 32'h00);
    checkOutput("rst_pend_clear", 32'(bus.stall), 32'h0);
    checkOutput("rst_ovf_clear", 32'(bus.sb_overflow), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/regfile_wb_port.md
Name: regfile_wb_port

Overview:
- Register-file side of the writeback interface of the 8-bit processor.
- Accepts the writeback stage's write strobe, destination index and selected data, and holds the architectural registers.
- Serves two combinational read ports to decode/operand fetch, with same-cycle write-through bypass.
- Keeps a per-register in-flight scoreboard and raises a stall when decode reads a register that still has an outstanding write.

Parameters:
- DATA_W, 8: register and data width.
- NREGS, 4: number of registers; index width AW = clog2(NREGS) = 2.
- MAX_INFLIGHT, 3: maximum outstanding writes per register; counter width CW = clog2(MAX_INFLIGHT+1) = 2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_we  in  1  writeback write strobe (WROut from writeback).
- wb_rd  in  AW  writeback destination index (rdOut).
- wb_data  in  DATA_W  writeback data (mux output: ACC or memory).
- iss_valid  in  1  decode issues an instruction that will write a register.
- iss_rd  in  AW  destination of the issued instruction.
- flush  in  1  squash all in-flight writes (branch/redirect).
- rs_addr  in  AW  read port A index.
- rt_addr  in  AW  read port B index.
- rs_data  out  DATA_W  read port A data.
- rt_data  out  DATA_W  read port B data.
- stall  out  1  decode must hold; an operand is pending.
- sb_overflow  out  1  sticky error: issue attempted on a counter already at MAX_INFLIGHT.

Behaviour:
- Reset (synchronous, rst=1 at the edge):
  - All registers are cleared to 0.
  - All pending counters are cleared to 0.
  - sb_overflow is cleared to 0.
  - rst has priority over every other input in that cycle.
- Write:
  - When wb_we=1, regs[wb_rd] <= wb_data at the edge; 1-cycle latency.
  - When wb_we=0, no register changes.
- Reads:
  - Combinational: rs_data = (wb_we && wb_rd==rs_addr) ? wb_data : regs[rs_addr].
  - rt_data is identical with rt_addr.
  - The bypass makes a value written this cycle visible in the same cycle.
- Scoreboard: pend[r] is a CW-bit counter per register.
  - inc[r] = iss_valid && iss_rd==r && !stall.
  - dec[r] = wb_we && wb_rd==r && pend[r]!=0.
  - inc and dec both set: count unchanged.
  - inc only: +1, saturating at MAX_INFLIGHT; at saturation sb_overflow <= 1 and stays set until rst.
  - dec only: -1.
  - wb_we to a register whose count is 0 still writes the data; the count stays 0 (no underflow).
  - flush=1: all counters <= 0 next edge. The same-cycle writeback data is still written. Same-cycle issue is ignored.
- Stall (combinational):
  - stall = (pend_eff[rs_addr]!=0) || (pend_eff[rt_addr]!=0).
  - pend_eff[r] = pend[r] minus 1 if dec[r] this cycle, so a write landing this cycle releases the stall immediately; the bypass supplies the data.
  - stall is 0 during rst and does not depend on iss_valid.
- Index equality: rs_addr==rt_addr is legal; both ports return the same value.

Decomposition:
- Shared package: DATA_W, NREGS, AW, MAX_INFLIGHT, CW constants and a register-index typedef.
- Also in the package: a reg_idx_t typedef, so writeback, decode and this block agree on index width.
- One natural sub-module, sb_counter: a saturating up/down counter with inc, dec, clr inputs and count and at_max outputs, instantiated NREGS times.
- The storage array and read/bypass muxes stay in the top level.

Test Plan:
- Reset then read: after rst, rs_addr=2, rt_addr=3 -> rs_data=0x00, rt_data=0x00, stall=0, sb_overflow=0.
- Write then read: wb_we=1, wb_rd=1, wb_data=0xA5 with rs_addr=1 -> same cycle rs_data=0xA5 (bypass); next cycle with wb_we=0 -> rs_data=0xA5 (stored).
- Hazard: iss_valid=1, iss_rd=2; next cycle rs_addr=2 -> stall=1; hold 2 cycles; then wb_we=1, wb_rd=2, wb_data=0x3C -> stall=0 that cycle and rs_data=0x3C.
- Simultaneous inc/dec: pend[0]=1; iss_valid=1, iss_rd=0 together with wb_we=1, wb_rd=0 -> pend[0] stays 1 and stall persists for reads of r0.
- Saturation: three issues to r3 with no writeback -> pend[3]=3; a fourth issue -> pend[3]=3, sb_overflow=1; sb_overflow stays set until rst.
- Flush and reset mid-operation: pend[1]=2, flush=1 with wb_we=1, wb_rd=1, wb_data=0x77 -> next cycle pend all 0 and regs[1]=0x77; then rst=1 with wb_we=1 -> regs[1]=0x00 (reset wins).
